button: RTL and testbench

BUTTON -- requirements
Module: button

---
 rtl/button.sv | 69 ++++++
 tb/tb_button.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/button.sv
// Debounced push-button: synchronizes the raw level, accepts a new level only after it has been
// stable for DEBOUNCE_CYCLES samples, and emits registered rise/fall pulses on each accepted change.
module button #(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic out,
    output logic out_rise,
    output logic out_fall
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   out_rise_q, out_rise_d;
    logic                   out_fall_q, out_fall_d;
    logic                   a_sync;

    assign a_sync   = sync_q[SYNC_STAGES-1];
    assign out      = out_q;
    assign out_rise = out_rise_q;
    assign out_fall = out_fall_q;

    // Next-state: synchronizer shift, stability count, and level acceptance with edge pulses.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], a};
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_rise_d = 1'b0;
        out_fall_d = 1'b0;
        if (a_sync == out_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            // Last required differing sample: take the new level and restart counting.
            out_d      = a_sync;
            cnt_d      = CNT_ZERO;
            out_rise_d = a_sync;
            out_fall_d = ~a_sync;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State register; reset clears everything, including an acceptance on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{1'b0}};
            cnt_q      <= CNT_ZERO;
            out_q      <= 1'b0;
            out_rise_q <= 1'b0;
            out_fall_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            out_rise_q <= out_rise_d;
            out_fall_q <= out_fall_d;
        end
    end

endmodule

// File: tb/tb_button.sv
// Bench for button: directed scenarios plus random bounce, compared each cycle against a
// sliding-window reference model of the debounce rule.
module tb_button;

    localparam int D = 500;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic out, out_rise, out_fall;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    logic apipe[$];
    logic hist[$];
    logic m_out  = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;

    button #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .a(a),
        .out(out), .out_rise(out_rise), .out_fall(out_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a_sync is `a` delayed S edges; level flips once the last D samples all differ.
    task automatic model(input logic a_v, input logic rst_v);
        logic s;
        bit all_diff;
        if (rst_v) begin
            apipe = {};
            for (int i = 0; i < S; i++) apipe.push_back(1'b0);
            hist.delete();
            m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            s = apipe[S-1];
            apipe.push_front(a_v);
            void'(apipe.pop_back());
            hist.push_back(s);
            if (hist.size() > D) void'(hist.pop_front());
            m_rise = 1'b0; m_fall = 1'b0;
            all_diff = (hist.size() == D);
            foreach (hist[i]) if (hist[i] == m_out) all_diff = 1'b0;
            if (all_diff) begin
                m_out  = ~m_out;
                m_rise = m_out;
                m_fall = ~m_out;
                hist.delete();
            end
        end
    endtask

    task automatic step(input logic a_v, input logic rst_v);
        @(negedge clk);
        a   = a_v;
        rst = rst_v;
        @(posedge clk);
        model(a_v, rst_v);
        #1;
        chk("out", out, m_out);
        chk("out_rise", out_rise, m_rise);
        chk("out_fall", out_fall, m_fall);
        checks++;
        assert (!(out_rise === 1'b1 && out_fall === 1'b1)) else begin
            failures++;
            $error("FAIL both_pulses observed=1 expected=0");
        end
        if (out_rise === 1'b1) rise_cnt++;
        if (out_fall === 1'b1) fall_cnt++;
    endtask

    task automatic hold(input logic a_v, input int n);
        for (int i = 0; i < n; i++) step(a_v, 1'b0);
    endtask

    // Drives a steadily and counts clocks (first sampling edge = 1) until out reaches target.
    task automatic latency(input logic a_v, input logic target, output int n);
        n = 0;
        do begin
            step(a_v, 1'b0);
            n++;
        end while (out !== target && n < 2000);
    endtask

    initial begin
        int n;
        int r0, f0;
        for (int i = 0; i < S; i++) apipe.push_back(1'b0);

        // Reset held 3 cycles with a=1
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("rst_out", out, 1'b0);
        chk("rst_rise", out_rise, 1'b0);
        chk("rst_fall", out_fall, 1'b0);
        step(1'b0, 1'b0);
        chk("post_rst_out", out, 1'b0);

        // One-cycle glitch rejected
        r0 = rise_cnt; f0 = fall_cnt;
        step(1'b1, 1'b0);
        hold(1'b0, 5000);
        chk("glitch_out", out, 1'b0);
        chk_int("glitch_pulses", rise_cnt + fall_cnt - r0 - f0, 0);

        // Stable rise latency
        r0 = rise_cnt;
        latency(1'b1, 1'b1, n);
        chk_int("rise_latency", n, D + S);
        hold(1'b1, 1000 - n);
        chk_int("rise_pulses", rise_cnt - r0, 1);
        chk("held_out", out, 1'b1);
        hold(1'b0, 600);
        chk("fall_back", out, 1'b0);

        // 499 cycles rejected, 500 accepted
        hold(1'b1, D - 1);
        hold(1'b0, 600);
        chk("short_499", out, 1'b0);
        hold(1'b1, D);
        hold(1'b0, 5);
        chk("exact_500", out, 1'b1);
        hold(1'b0, 600);
        chk("settle_low", out, 1'b0);

        // Toggle every 100 cycles, then hold high
        for (int k = 0; k < 20; k++) hold((k % 2 == 0) ? 1'b1 : 1'b0, 100);
        chk("toggle_out", out, 1'b0);
        latency(1'b1, 1'b1, n);
        chk_int("toggle_latency", n, D + S);

        // Mid-count reset on a high output
        hold(1'b1, 300);
        step(1'b1, 1'b1);
        chk("rst_mid_out", out, 1'b0);
        latency(1'b1, 1'b1, n);
        chk_int("rst_release_latency", n, D + S);
        f0 = fall_cnt;
        latency(1'b0, 1'b0, n);
        chk_int("fall_latency", n, D + S);
        hold(1'b0, 20);
        chk_int("fall_pulses", fall_cnt - f0, 1);

        // Reset landing mid-count discards progress
        hold(1'b1, 400);
        step(1'b1, 1'b1);
        hold(1'b1, 200);
        chk("rst_discard", out, 1'b0);
        hold(1'b1, 400);
        chk("rst_discard_done", out, 1'b1);

        // Random bounce bursts and holds
        for (int k = 0; k < 40; k++) begin
            int len;
            logic lv;
            lv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(D - 3, D + 80) : $urandom_range(1, 60);
            if ($urandom_range(0, 15) == 0) step(lv, 1'b1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0 && len < D) step(~lv, 1'b0);
                else step(lv, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
